// File: rtl/des_key_sched.sv
// Iterative DES key schedule: PC-1 load, per-round 28-bit rotations of C/D, PC-2 output.
// Emits K1..K16 (encrypt) or K16..K1 (decrypt) over a valid/ready handshake.
module des_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        busy,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] sk,
  output logic [3:0]  sk_round,
  output logic        sk_last
);

  typedef enum logic [0:0] {StIdle, StGen} state_e;

  // FIPS 46-3 bit numbers (1 = MSB) selected for each output bit, MSB first.
  localparam int unsigned Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Entry i holds the rotation amount for round i+1.
  localparam logic [1:0] ShTab [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] res;
    logic [5:0]  idx;
    res = '0;
    for (int i = 0; i < 56; i++) begin
      idx = 6'(64 - Pc1Tab[i]);
      res = {res[54:0], k[idx]};
    end
    return res;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] res;
    logic [5:0]  idx;
    res = '0;
    for (int i = 0; i < 48; i++) begin
      idx = 6'(56 - Pc2Tab[i]);
      res = {res[46:0], cd[idx]};
    end
    return res;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  step_q, step_d;
  logic [55:0] key_cd;
  logic [1:0]  sh_enc, sh_dec;

  assign key_cd = pc1(key);
  assign sh_enc = ShTab[step_q + 4'd1];
  // Decrypt walks C/D backwards: undo the rotation that produced the subkey just shown.
  assign sh_dec = ShTab[~step_q];

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    c_d     = c_q;
    d_d     = d_q;
    step_d  = step_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StGen;
          mode_d  = decrypt;
          step_d  = 4'd0;
          // Total rotation over 16 rounds is 28, so C16/D16 equals the unrotated load.
          if (decrypt) begin
            c_d = key_cd[55:28];
            d_d = key_cd[27:0];
          end else begin
            c_d = rotl(key_cd[55:28], ShTab[0]);
            d_d = rotl(key_cd[27:0], ShTab[0]);
          end
        end
      end
      StGen: begin
        if (sk_ready) begin
          if (step_q == 4'd15) begin
            state_d = StIdle;
          end else begin
            step_d = step_q + 4'd1;
            if (mode_q) begin
              c_d = rotr(c_q, sh_dec);
              d_d = rotr(d_q, sh_dec);
            end else begin
              c_d = rotl(c_q, sh_enc);
              d_d = rotl(d_q, sh_enc);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      c_q     <= '0;
      d_q     <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      d_q     <= d_d;
      step_q  <= step_d;
    end
  end

  assign sk_valid = (state_q == StGen);
  assign busy     = (state_q == StGen);
  assign sk       = pc2({c_q, d_q});
  assign sk_round = mode_q ? ~step_q : step_q;
  assign sk_last  = sk_valid && (step_q == 4'd15);

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched using the classic 0x133457799BBCDFF1 subkey vector.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] key = '0;
  logic        decrypt = 1'b0;
  logic        busy;
  logic        sk_valid;
  logic        sk_ready = 1'b1;
  logic [47:0] sk;
  logic [3:0]  sk_round;
  logic        sk_last;

  des_key_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .decrypt  (decrypt),
    .busy     (busy),
    .sk_valid (sk_valid),
    .sk_ready (sk_ready),
    .sk       (sk),
    .sk_round (sk_round),
    .sk_last  (sk_last)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] KeyA = 64'h133457799BBCDFF1;

  logic [47:0] exp_k [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  int pass_cnt = 0;
  int total    = 0;

  logic [47:0] cap_sk   [16];
  logic [3:0]  cap_rnd  [16];
  logic        cap_last [16];
  logic [47:0] enc_seq  [16];
  int          cap_n, cap_valid, cap_cycles, cap_stall_err;
  bit          cap_timeout;

  // Runs one full key schedule and records every accepted subkey.
  task automatic run_capture(input logic [63:0] k, input logic dec, input bit stall,
                             input int inject_at);
    logic [47:0] held_sk;
    logic [3:0]  held_rnd;
    bit          held;
    cap_n = 0; cap_valid = 0; cap_cycles = 0; cap_stall_err = 0; cap_timeout = 0; held = 0;
    held_sk = '0; held_rnd = '0;
    @(negedge clk);
    key = k; decrypt = dec; start = 1'b1;
    sk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cap_n < 16 && !cap_timeout) begin
      @(negedge clk);
      if (sk_valid) begin
        cap_valid++;
        if (held && (sk !== held_sk || sk_round !== held_rnd)) cap_stall_err++;
        if (sk_ready) begin
          cap_sk[cap_n] = sk; cap_rnd[cap_n] = sk_round; cap_last[cap_n] = sk_last;
          cap_n++;
          held = 0;
        end else begin
          held = 1; held_sk = sk; held_rnd = sk_round;
        end
      end
      @(posedge clk); #1;
      cap_cycles++;
      sk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject_at >= 0 && cap_n == inject_at && start == 1'b0 && cap_n < 16 &&
          key == k) begin
        start = 1'b1; key = 64'h0;
      end else begin
        start = 1'b0; key = k;
      end
      if (cap_cycles > 200) cap_timeout = 1;
    end
    start = 1'b0; key = k; sk_ready = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (sk_valid !== 1'b0) $display("FAIL reset_sk_valid got %b want 0", sk_valid);
    else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else pass_cnt++;
    total++; if (sk !== 48'h0) $display("FAIL reset_sk got %h want 0", sk);
    else pass_cnt++;
    total++; if (sk_round !== 4'd0) $display("FAIL reset_sk_round got %0d want 0", sk_round);
    else pass_cnt++;
    total++; if (sk_last !== 1'b0) $display("FAIL reset_sk_last got %b want 0", sk_last);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_enc_run(input string tag);
    total++; if (cap_timeout) $display("FAIL %s_timeout got %0d subkeys want 16", tag, cap_n);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cap_sk[i] !== exp_k[i] || cap_rnd[i] !== 4'(i) || cap_last[i] !== (i == 15))
        $display("FAIL %s_k%0d got sk=%h rnd=%0d last=%b want sk=%h rnd=%0d last=%b", tag,
                 i + 1, cap_sk[i], cap_rnd[i], cap_last[i], exp_k[i], i, (i == 15));
      else pass_cnt++;
    end
  endtask

  task automatic check_dec_run(input string tag);
    total++; if (cap_timeout) $display("FAIL %s_timeout got %0d subkeys want 16", tag, cap_n);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cap_sk[i] !== exp_k[15-i] || cap_rnd[i] !== 4'(15 - i) || cap_last[i] !== (i == 15))
        $display("FAIL %s_k%0d got sk=%h rnd=%0d last=%b want sk=%h rnd=%0d last=%b", tag,
                 16 - i, cap_sk[i], cap_rnd[i], cap_last[i], exp_k[15-i], 15 - i, (i == 15));
      else pass_cnt++;
    end
  endtask

  task automatic test_encrypt();
    run_capture(KeyA, 1'b0, 1'b0, -1);
    check_enc_run("enc");
    for (int i = 0; i < 16; i++) enc_seq[i] = cap_sk[i];
    total++; if (cap_valid !== 16 || cap_cycles !== 16)
      $display("FAIL enc_valid_cycles got %0d/%0d want 16/16", cap_valid, cap_cycles);
    else pass_cnt++;
    @(negedge clk);
    total++; if (busy !== 1'b0 || sk_valid !== 1'b0)
      $display("FAIL enc_idle_after got busy=%b valid=%b want 0/0", busy, sk_valid);
    else pass_cnt++;
  endtask

  task automatic test_decrypt();
    run_capture(KeyA, 1'b1, 1'b0, -1);
    check_dec_run("dec");
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cap_sk[i] !== enc_seq[15-i])
        $display("FAIL dec_reverse[%0d] got %h want %h", i, cap_sk[i], enc_seq[15-i]);
      else pass_cnt++;
    end
    total++; if (cap_cycles !== 16)
      $display("FAIL dec_cycles got %0d want 16", cap_cycles);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    run_capture(KeyA, 1'b0, 1'b1, -1);
    check_enc_run("bp_enc");
    total++; if (cap_stall_err !== 0)
      $display("FAIL bp_enc_stall_hold got %0d changes want 0", cap_stall_err);
    else pass_cnt++;
    run_capture(KeyA, 1'b1, 1'b1, -1);
    check_dec_run("bp_dec");
    total++; if (cap_stall_err !== 0)
      $display("FAIL bp_dec_stall_hold got %0d changes want 0", cap_stall_err);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    run_capture(KeyA, 1'b0, 1'b0, 5);
    check_enc_run("busy_start");
    repeat (3) begin
      @(negedge clk);
      total++; if (sk_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL busy_start_no_rerun got valid=%b busy=%b want 0/0", sk_valid, busy);
      else pass_cnt++;
    end
    run_capture(KeyA, 1'b1, 1'b0, -1);
    check_dec_run("busy_next");
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    key = KeyA; decrypt = 1'b1; start = 1'b1; sk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    total++; if (sk_round !== 4'd8 || sk_valid !== 1'b1)
      $display("FAIL rst_pre_round got rnd=%0d valid=%b want 8/1", sk_round, sk_valid);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total++; if (sk_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_async got valid=%b busy=%b want 0/0", sk_valid, busy);
    else pass_cnt++;
    total++; if (sk !== 48'h0 || sk_round !== 4'd0)
      $display("FAIL rst_async_sk got sk=%h rnd=%0d want 0/0", sk, sk_round);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    run_capture(KeyA, 1'b1, 1'b0, -1);
    check_dec_run("rst_rerun");
  endtask

  task automatic test_parity();
    run_capture(KeyA ^ 64'h0101010101010101, 1'b0, 1'b0, -1);
    check_enc_run("parity");
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_start_while_busy();
    test_reset_midrun();
    test_parity();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish before 2ms");
    $fatal(1);
  end

endmodule
